// File: rtl/hog_pkg.sv
// Shared types and sizing helpers for the HOG-to-SVM pixel feed path.
package hog_pkg;

  localparam int unsigned PIX_W_DEF = 8;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  function automatic int unsigned in_w(input int unsigned pix_w);
    return pix_w * 4;
  endfunction

  function automatic int unsigned n_word(input int unsigned w, input int unsigned h);
    return (w * h) / 4;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Prefetch FIFO: head word is visible on dout whenever not empty.
module pix_fifo #(
  parameter int unsigned W = 32,
  parameter int unsigned D = 4,
  localparam int unsigned AW = $clog2(D),
  localparam int unsigned OW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic          full,
  output logic [OW-1:0] occ
);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          do_push, do_pop;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OW'(D));
  assign occ     = occ_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      occ_d = occ_q + 1'b1;
      else if (do_pop && !do_push) occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/pix_feeder.sv
// Streams one frame of 4-pixel words from frame memory to the pipeline's
// request/ready handshake, prefetching through a small FIFO.
module pix_feeder
  import hog_pkg::*;
#(
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned FIFO_D = 4,
  localparam int unsigned IN_W   = in_w(PIX_W),
  localparam int unsigned N_WORD = n_word(IMG_W, IMG_H),
  localparam int unsigned MA_W   = $clog2(N_WORD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            frame_done,
  output logic            mem_rd,
  output logic [MA_W-1:0] mem_addr,
  input  logic [IN_W-1:0] mem_data,
  input  logic            request,
  output logic            ready,
  output logic [IN_W-1:0] i_data
);

  localparam int unsigned CNT_W = $clog2(N_WORD + 1);
  localparam int unsigned OCC_W = $clog2(FIFO_D) + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] deliv_q, deliv_d;
  logic             inflight_q;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [IN_W-1:0]  data_q, data_d;
  logic             rd_en;
  logic [OCC_W:0]   credit;

  logic             fifo_clear, fifo_push, fifo_pop;
  logic             fifo_empty, fifo_full;
  logic [IN_W-1:0]  fifo_dout;
  logic [OCC_W-1:0] fifo_occ;

  pix_fifo #(
    .W (IN_W),
    .D (FIFO_D)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mem_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .occ   (fifo_occ)
  );

  // Read data lands one cycle after the strobe; the credit check already
  // reserves its slot, so the full guard never actually blocks a push.
  assign fifo_push  = inflight_q && !fifo_full;
  assign credit     = {1'b0, fifo_occ} + (OCC_W+1)'(inflight_q);

  assign busy       = (state_q == STREAM);
  assign mem_rd     = rd_en;
  assign mem_addr   = issued_q[MA_W-1:0];
  assign ready      = ready_q;
  assign i_data     = data_q;
  assign frame_done = done_q;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    deliv_d    = deliv_q;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    data_d     = data_q;
    fifo_clear = 1'b0;
    fifo_pop   = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = STREAM;
          issued_d   = '0;
          deliv_d    = '0;
          fifo_clear = 1'b1;
        end
      end
      STREAM: begin
        rd_en = (issued_q < CNT_W'(N_WORD)) && (credit < (OCC_W+1)'(FIFO_D));
        if (rd_en) issued_d = issued_q + 1'b1;
        if (request && !fifo_empty) begin
          fifo_pop = 1'b1;
          ready_d  = 1'b1;
          data_d   = fifo_dout;
          deliv_d  = deliv_q + 1'b1;
          done_d   = (deliv_q == CNT_W'(N_WORD - 1));
        end
        // done_q marks the cycle of the last ready; leave on the next edge.
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      deliv_q    <= '0;
      inflight_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      deliv_q    <= deliv_d;
      inflight_q <= rd_en;
      ready_q    <= ready_d;
      done_q     <= done_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_pix_feeder.sv
// Scoreboard bench for pix_feeder on a 4-word frame (8x2 pixels, depth-4 FIFO).
module tb_pix_feeder;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 2;
  localparam int unsigned FIFO_D = 4;
  localparam int unsigned IN_W   = 32;
  localparam int unsigned MA_W   = 2;
  localparam logic [31:0] BASE   = 32'h0A0B0C00;

  logic            clk, rst, start, busy, frame_done, mem_rd, request, ready;
  logic [MA_W-1:0] mem_addr;
  logic [IN_W-1:0] mem_data, i_data;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_exp;
  int          cyc;
  int          rd_count;
  int          n_cmp;
  int          n_err;
  int          e0;
  int          rd_base;

  pix_feeder #(
    .PIX_W  (PIX_W),
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .FIFO_D (FIFO_D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .request    (request),
    .ready      (ready),
    .i_data     (i_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc      = 0;
    rd_count = 0;
    mem_data = '0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) begin
      mem_data <= BASE + 32'(mem_addr);
      rd_count <= rd_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every ready strobe, checks hold otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_exp = '0;
    end else if (ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: got ready=1 data=%h, required no strobe (cycle %0d)", i_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ready_data", i_data, mon_e.data);
        chk("frame_done_at_strobe", 32'(frame_done), 32'(mon_e.last));
        chk("ready_cycle", mon_e.cyc, cyc);
        last_exp = mon_e.data;
      end
    end else begin
      chk("data_hold", i_data, last_exp);
      chk("frame_done_idle", 32'(frame_done), 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input int c);
    exp_t e;
    e.data = BASE + 32'(k);
    e.cyc  = c;
    e.last = (k == 3);
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) tick(1);
    chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    last_exp = '0;
    rst      = 1'b1;
    start    = 1'b0;
    request  = 1'b0;
    tick(2);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_i_data", i_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    tick(2);

    // Full frame with request held high.
    request = 1'b1;
    e0 = cyc;
    for (int k = 0; k < 4; k++) push_exp(k, e0 + 4 + k);
    pulse_start();
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_mem_rd_c1", 32'(mem_rd), 32'd1);
    chk("t1_addr_c1", 32'(mem_addr), 32'd0);
    tick(6);
    chk("t1_busy_c7", 32'(busy), 32'd1);
    tick(1);
    chk("t1_busy_c8", 32'(busy), 32'd0);
    tick(2);
    chk("t1_drain", sb.size(), 32'd0);

    // Request low: prefetch fills, then a burst from cycle 21.
    request = 1'b0;
    e0 = cyc;
    rd_base = rd_count;
    for (int k = 0; k < 4; k++) push_exp(k, e0 + 21 + k);
    pulse_start();
    tick(18);
    chk("t2_mem_rd_c19", 32'(mem_rd), 32'd0);
    chk("t2_busy_c19", 32'(busy), 32'd1);
    tick(1);
    chk("t2_reads", rd_count - rd_base, 32'd4);
    request = 1'b1;
    wait_idle(30);
    tick(2);
    chk("t2_drain", sb.size(), 32'd0);

    // Toggling request 1,0,1,0 once the FIFO is full.
    request = 1'b0;
    e0 = cyc;
    for (int k = 0; k < 4; k++) push_exp(k, e0 + 7 + 2 * k);
    pulse_start();
    tick(5);
    for (int k = 0; k < 8; k++) begin
      request = (k % 2 == 0);
      tick(1);
    end
    wait_idle(20);
    tick(2);
    chk("t3_drain", sb.size(), 32'd0);

    // Second start mid-frame must be ignored.
    request = 1'b1;
    e0 = cyc;
    rd_base = rd_count;
    for (int k = 0; k < 4; k++) push_exp(k, e0 + 4 + k);
    pulse_start();
    tick(3);
    pulse_start();
    wait_idle(20);
    tick(5);
    chk("t4_reads", rd_count - rd_base, 32'd4);
    chk("t4_busy_after", 32'(busy), 32'd0);
    chk("t4_drain", sb.size(), 32'd0);

    // Reset right after the 2nd ready, then restart from address 0.
    e0 = cyc;
    for (int k = 0; k < 4; k++) push_exp(k, e0 + 4 + k);
    pulse_start();
    tick(4);
    @(negedge clk);
    #1;
    rst = 1'b1;
    chk("t5_consumed_two", sb.size(), 32'd2);
    sb.delete();
    #1;
    chk("t5_rst_ready", 32'(ready), 32'd0);
    chk("t5_rst_i_data", i_data, 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_frame_done", 32'(frame_done), 32'd0);
    chk("t5_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    e0 = cyc;
    for (int k = 0; k < 4; k++) push_exp(k, e0 + 4 + k);
    pulse_start();
    chk("t5_restart_mem_rd", 32'(mem_rd), 32'd1);
    chk("t5_restart_addr", 32'(mem_addr), 32'd0);
    wait_idle(20);
    tick(2);
    chk("t5_drain", sb.size(), 32'd0);

    // Request high in IDLE without start.
    request = 1'b1;
    for (int i = 0; i < 50; i++) begin
      chk("t6_ready", 32'(ready), 32'd0);
      chk("t6_mem_rd", 32'(mem_rd), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      tick(1);
    end
    chk("t6_drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pix_feeder.md
# pix_feeder

Pixel source for the HOG-to-SVM pipeline. It answers the pipeline's `request`/`ready` pixel handshake: when the pipeline asks for data, the block supplies 4-pixel words in raster order. Words come from a frame memory with a 1-cycle read latency, staged through a small prefetch FIFO so that one word per cycle can be sustained. One frame is streamed per `start` pulse.

## Interface
Parameters:
- `PIX_W`, default 8, bits per pixel.
- `IMG_W`, default 640, frame width in pixels; must be a multiple of 4.
- `IMG_H`, default 480, frame height in pixels.
- `FIFO_D`, default 4, prefetch depth; must be a power of 2 and at least 2.
- `IN_W` (localparam) = `PIX_W*4`.
- `N_WORD` (localparam) = `IMG_W*IMG_H/4`.
- `MA_W` (localparam) = `$clog2(N_WORD)`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame.
- `busy`  out  1  high while a frame is in progress.
- `frame_done`  out  1  one-cycle pulse coincident with the last `ready`.
- `mem_rd`  out  1  frame-memory read strobe.
- `mem_addr`  out  MA_W  word address.
- `mem_data`  in  IN_W  read data, valid the cycle after `mem_rd`.
- `request`  in  1  level from the consumer: it can accept words.
- `ready`  out  1  strobe: `i_data` holds a valid word this cycle.
- `i_data`  out  IN_W  pixel word (4 pixels, lowest column in `[PIX_W-1:0]`).

## Operation
- States: IDLE and STREAM.
- IDLE to STREAM: `start` sampled high. On entry, the issue counter, the delivered counter and the FIFO are cleared.
- `start` while in STREAM is ignored.
- STREAM to IDLE: on the cycle after the N_WORD-th `ready`.
- Read issue (combinational), in STREAM: `mem_rd = (issued < N_WORD) && (occ + inflight < FIFO_D)`.
  - `mem_addr = issued`.
  - `issued` increments on each read.
  - `inflight` is 1 in the cycle after a read.
- FIFO write: `mem_data` is pushed in the cycle after `mem_rd`. The credit rule guarantees it is never pushed while full.
- Pop and deliver: if `request && !empty` in cycle t, the head is popped. In cycle t+1, `ready=1` and `i_data` holds the popped word.
- `ready` is registered. `i_data` holds its last value while `ready=0`.
- The consumer must absorb any `ready` that arrives in the cycle after it drops `request`.
- A simultaneous push and pop keeps occupancy unchanged. The FIFO wraps modulo FIFO_D.
- Word content is passed through unmodified; there is no arithmetic on pixels.
- `request` in IDLE is ignored.
- Reset mid-frame returns the block to IDLE and discards the FIFO contents and counters.
- Reset values: `ready=0`, `i_data=0`, `busy=0`, `frame_done=0`, `mem_rd=0`, `mem_addr=0`.

## Timing
- `start` high in cycle 0 gives `busy=1` from cycle 1.
- First read: `mem_rd=1`, `addr=0` in cycle 1.
- Data is captured at the end of cycle 2, and the FIFO is non-empty in cycle 3.
- With `request` high in cycle 3, the earliest `ready` is in cycle 4.
- With `request` held high and FIFO_D ≥ 2, `ready` is continuous, one word per cycle.
- `frame_done` is high in the same cycle as the last `ready`. `busy` falls in the next cycle.
- With `request` low, at most FIFO_D reads are outstanding, and `mem_rd` stays low until a pop frees a slot.

## Structure
- Package `hog_pkg`: `PIX_W` default, an `IN_W` helper, a `state_t` enum (IDLE, STREAM), and a `n_word(w,h)` function.
- Sub-module `pix_fifo`: synchronous FIFO with width IN_W and depth FIFO_D. It exposes `push`, `pop`, `din`, `dout`, `empty`, `full` and `occ`.
- Top-level: state register, counters, issue logic and output registers.

## Test plan
For all tests, use `IMG_W=8`, `IMG_H=2` (N_WORD=4) and a memory model with `mem[k]=32'h0A0B0C00+k`.

- Full frame, `request` always high, `start` at cycle 0:
  - `ready` high in cycles 4–7.
  - `i_data` = `0A0B0C00` through `0A0B0C03`.
  - `frame_done` in cycle 7; `busy=0` in cycle 8.
- `request` low after `start`:
  - Exactly 4 reads are issued (FIFO_D=4) and `ready` stays 0.
  - `request` raised in cycle 20 gives 4 consecutive `ready` strobes from cycle 21.
- `request` toggling 1,0,1,0:
  - Each `ready` follows a high `request` by one cycle.
  - Words arrive in order with no loss or duplication.
  - `i_data` holds between strobes.
- `start` pulsed again mid-frame: ignored. Exactly 4 words are delivered and `frame_done` pulses once.
- `rst` asserted after the 2nd `ready`:
  - All outputs go to 0 immediately (asynchronously).
  - A new `start` restarts from address 0 with first word `0A0B0C00`.
- `request` high in IDLE with no `start`: `ready`, `mem_rd` and `busy` stay 0 for 50 cycles.
